// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared defaults, latency classes and entry operation type for the register scoreboard
package reg_scoreboard_pkg;

    localparam int NUM_REGS_DEF    = 32;
    localparam int ADDR_W_DEF      = 5;
    localparam int LAT_W_DEF       = 3;
    localparam int STALL_CNT_W_DEF = 16;

    localparam int REG_X0   = 0;
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;

    // Per-entry update selected by the top level, highest priority first: flush, set, clear
    typedef enum logic [1:0] {
        ENT_HOLD  = 2'd0,
        ENT_SET   = 2'd1,
        ENT_CLR   = 2'd2,
        ENT_FLUSH = 2'd3
    } entry_op_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/status bundle between the ID stage and the register scoreboard
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LAT_W       = LAT_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
);
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_rs1;
    logic [ADDR_W-1:0]      issue_rs2;
    logic                   issue_rs1_used;
    logic                   issue_rs2_used;
    logic [ADDR_W-1:0]      issue_rd;
    logic                   issue_rd_wr;
    logic [LAT_W-1:0]       issue_lat;
    logic                   issue_ready;
    logic                   fwd_rs1;
    logic                   fwd_rs2;
    logic                   wb_valid;
    logic [ADDR_W-1:0]      wb_rd;
    logic                   flush;
    logic [ADDR_W:0]        busy_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   wb_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_wr, issue_lat, wb_valid, wb_rd, flush,
        input  issue_ready, fwd_rs1, fwd_rs2, busy_cnt, stall_cnt, wb_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_wr, issue_lat, wb_valid, wb_rd, flush,
        output issue_ready, fwd_rs1, fwd_rs2, busy_cnt, stall_cnt, wb_err
    );
endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// rtl/reg_scoreboard_sb_entry.sv - one tracked register: busy bit plus result-ready countdown
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  entry_op_e        op,
    input  logic [LAT_W-1:0] lat,
    output logic             busy,
    output logic             busy_nxt,
    output logic [LAT_W-1:0] cnt
);

    // busy_nxt is exported so the top can register the busy popcount in step with the entries
    always_comb begin
        busy_nxt = busy;
        case (op)
            ENT_SET:           busy_nxt = 1'b1;
            ENT_CLR, ENT_FLUSH: busy_nxt = 1'b0;
            default:           busy_nxt = busy;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else begin
            busy <= busy_nxt;
            case (op)
                ENT_SET:            cnt <= lat;
                ENT_CLR, ENT_FLUSH: cnt <= '0;
                default: begin
                    if (cnt != '0)
                        cnt <= cnt - LAT_W'(1);
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard: per-register busy/countdown tracking, hazard and forward decisions
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LAT_W       = LAT_W_DEF,
    parameter bit FWD_EN      = 1'b1,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [LAT_W-1:0]    cnt [NUM_REGS];

    logic                   rs1_haz, rs2_haz, waw, ready, fire;
    logic [ADDR_W:0]        busy_pop;
    logic [ADDR_W:0]        busy_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   wb_err_q;

    assign busy[REG_X0]     = 1'b0;
    assign busy_nxt[REG_X0] = 1'b0;
    assign cnt[REG_X0]      = '0;

    // Hazards look only at registered state; a writeback in this cycle does not unblock until the next
    assign rs1_haz = sb.issue_rs1_used && (sb.issue_rs1 != '0) && busy[sb.issue_rs1]
                     && ((cnt[sb.issue_rs1] != '0) || !FWD_EN);
    assign rs2_haz = sb.issue_rs2_used && (sb.issue_rs2 != '0) && busy[sb.issue_rs2]
                     && ((cnt[sb.issue_rs2] != '0) || !FWD_EN);
    assign waw     = sb.issue_rd_wr && (sb.issue_rd != '0) && busy[sb.issue_rd];
    assign ready   = !sb.flush && !rs1_haz && !rs2_haz && !waw;
    assign fire    = sb.issue_valid && ready && sb.issue_rd_wr && (sb.issue_rd != '0);

    assign sb.issue_ready = ready;
    assign sb.fwd_rs1 = FWD_EN && sb.issue_rs1_used && (sb.issue_rs1 != '0)
                        && busy[sb.issue_rs1] && (cnt[sb.issue_rs1] == '0);
    assign sb.fwd_rs2 = FWD_EN && sb.issue_rs2_used && (sb.issue_rs2 != '0)
                        && busy[sb.issue_rs2] && (cnt[sb.issue_rs2] == '0);

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            entry_op_e op;

            always_comb begin
                op = ENT_HOLD;
                if (sb.flush)
                    op = ENT_FLUSH;
                else if (fire && (sb.issue_rd == ADDR_W'(r)))
                    op = ENT_SET;
                else if (sb.wb_valid && (sb.wb_rd == ADDR_W'(r)))
                    op = ENT_CLR;
            end

            sb_entry #(.LAT_W(LAT_W)) u_entry (
                .clk      (clk),
                .rst      (rst),
                .op       (op),
                .lat      (sb.issue_lat),
                .busy     (busy[r]),
                .busy_nxt (busy_nxt[r]),
                .cnt      (cnt[r])
            );
        end
    endgenerate

    always_comb begin
        busy_pop = '0;
        for (int i = 0; i < NUM_REGS; i++)
            busy_pop = busy_pop + (ADDR_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_cnt_q <= busy_pop;
            if (sb.issue_valid && !ready && !sb.flush && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            if (!sb.flush && sb.wb_valid && (sb.wb_rd != '0) && !busy[sb.wb_rd])
                wb_err_q <= 1'b1;
        end
    end

    assign sb.busy_cnt  = busy_cnt_q;
    assign sb.stall_cnt = stall_cnt_q;
    assign sb.wb_err    = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard bench: forwarding and stall-only instances against a behavioural register model
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.ADDR_W(5), .LAT_W(3), .STALL_CNT_W(16)) bus0 ();
    reg_scoreboard_if #(.ADDR_W(5), .LAT_W(3), .STALL_CNT_W(4))  bus1 ();

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LAT_W(3), .FWD_EN(1'b1), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .sb(bus0));
    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LAT_W(3), .FWD_EN(1'b0), .STALL_CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .sb(bus1));

    typedef struct {
        int m;
        int ready;
        int fwd1;
        int fwd2;
        int bcnt;
        int stall;
        int err;
    } exp_t;

    exp_t expq[$];
    int tests = 0;
    int failed = 0;

    // Reference model: instance 0 forwards, instance 1 stalls on any busy source
    int mbusy [2][32];
    int mcnt  [2][32];
    int merr  [2];
    int mstall[2];
    int stall_max[2] = '{65535, 15};

    int s_valid, s_rs1, s_rs2, s_u1, s_u2, s_rd, s_wr, s_lat, s_flush;
    int s_wbv[2];
    int s_wbr[2];

    task automatic check(input string name, input int m, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s[inst%0d] t=%0t: got %0d expected %0d", name, m, $time, act, exp);
        end
    endtask

    function automatic int haz(input int m, input int used, input int s);
        return (used != 0 && s != 0 && mbusy[m][s] != 0 && (mcnt[m][s] != 0 || m == 1)) ? 1 : 0;
    endfunction

    function automatic int fwd(input int m, input int used, input int s);
        return (m == 0 && used != 0 && s != 0 && mbusy[m][s] != 0 && mcnt[m][s] == 0) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) begin
                mbusy[m][r] = 0;
                mcnt[m][r]  = 0;
            end
            merr[m]   = 0;
            mstall[m] = 0;
        end
    endtask

    task automatic set_idle();
        s_valid = 0; s_rs1 = 0; s_rs2 = 0; s_u1 = 0; s_u2 = 0;
        s_rd = 0; s_wr = 0; s_lat = 0; s_flush = 0;
        s_wbv = '{0, 0};
        s_wbr = '{0, 0};
    endtask

    task automatic drive();
        bus0.issue_valid = 1'(s_valid);  bus1.issue_valid = 1'(s_valid);
        bus0.issue_rs1 = 5'(s_rs1);      bus1.issue_rs1 = 5'(s_rs1);
        bus0.issue_rs2 = 5'(s_rs2);      bus1.issue_rs2 = 5'(s_rs2);
        bus0.issue_rs1_used = 1'(s_u1);  bus1.issue_rs1_used = 1'(s_u1);
        bus0.issue_rs2_used = 1'(s_u2);  bus1.issue_rs2_used = 1'(s_u2);
        bus0.issue_rd = 5'(s_rd);        bus1.issue_rd = 5'(s_rd);
        bus0.issue_rd_wr = 1'(s_wr);     bus1.issue_rd_wr = 1'(s_wr);
        bus0.issue_lat = 3'(s_lat);      bus1.issue_lat = 3'(s_lat);
        bus0.flush = 1'(s_flush);        bus1.flush = 1'(s_flush);
        bus0.wb_valid = 1'(s_wbv[0]);    bus1.wb_valid = 1'(s_wbv[1]);
        bus0.wb_rd = 5'(s_wbr[0]);       bus1.wb_rd = 5'(s_wbr[1]);
    endtask

    // One clock: drive at the falling edge, queue expectations, then advance the model across the rising edge
    task automatic cycle();
        exp_t e;
        int fire, wb, nb;
        @(negedge clk);
        drive();
        for (int m = 0; m < 2; m++) begin
            nb = 0;
            for (int r = 0; r < 32; r++) nb += mbusy[m][r];
            e.m     = m;
            e.ready = (s_flush == 0 && haz(m, s_u1, s_rs1) == 0 && haz(m, s_u2, s_rs2) == 0
                       && !(s_wr != 0 && s_rd != 0 && mbusy[m][s_rd] != 0)) ? 1 : 0;
            e.fwd1  = fwd(m, s_u1, s_rs1);
            e.fwd2  = fwd(m, s_u2, s_rs2);
            e.bcnt  = nb;
            e.stall = mstall[m];
            e.err   = merr[m];
            expq.push_back(e);

            if (s_valid != 0 && e.ready == 0 && s_flush == 0 && mstall[m] < stall_max[m])
                mstall[m]++;
            if (s_flush != 0) begin
                for (int r = 0; r < 32; r++) begin
                    mbusy[m][r] = 0;
                    mcnt[m][r]  = 0;
                end
            end else begin
                fire = (s_valid != 0 && e.ready != 0 && s_wr != 0 && s_rd != 0) ? 1 : 0;
                wb   = (s_wbv[m] != 0 && s_wbr[m] != 0) ? 1 : 0;
                if (wb != 0 && mbusy[m][s_wbr[m]] == 0) merr[m] = 1;
                for (int r = 1; r < 32; r++) begin
                    if (fire != 0 && r == s_rd) begin
                        mbusy[m][r] = 1;
                        mcnt[m][r]  = s_lat;
                    end else if (wb != 0 && r == s_wbr[m]) begin
                        mbusy[m][r] = 0;
                        mcnt[m][r]  = 0;
                    end else if (mbusy[m][r] != 0 && mcnt[m][r] > 0) begin
                        mcnt[m][r]--;
                    end
                end
            end
        end
    endtask

    task automatic issue(input int rd, input int lat);
        set_idle();
        s_valid = 1; s_rd = rd; s_wr = 1; s_lat = lat;
        cycle();
    endtask

    task automatic wb_both(input int rd);
        s_wbv = '{1, 1};
        s_wbr = '{rd, rd};
    endtask

    task automatic do_reset();
        set_idle();
        drive();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_clear();
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.m == 0) begin
                    check("issue_ready", 0, int'(bus0.issue_ready), e.ready);
                    check("fwd_rs1", 0, int'(bus0.fwd_rs1), e.fwd1);
                    check("fwd_rs2", 0, int'(bus0.fwd_rs2), e.fwd2);
                    check("busy_cnt", 0, int'(bus0.busy_cnt), e.bcnt);
                    check("stall_cnt", 0, int'(bus0.stall_cnt), e.stall);
                    check("wb_err", 0, int'(bus0.wb_err), e.err);
                end else begin
                    check("issue_ready", 1, int'(bus1.issue_ready), e.ready);
                    check("fwd_rs1", 1, int'(bus1.fwd_rs1), e.fwd1);
                    check("fwd_rs2", 1, int'(bus1.fwd_rs2), e.fwd2);
                    check("busy_cnt", 1, int'(bus1.busy_cnt), e.bcnt);
                    check("stall_cnt", 1, int'(bus1.stall_cnt), e.stall);
                    check("wb_err", 1, int'(bus1.wb_err), e.err);
                end
            end
        end
    end

    initial begin : stimulus
        int start, pick;
        model_clear();
        do_reset();
        set_idle();
        cycle();

        // rd=5 lat=0 then an rs1 consumer, then writeback
        issue(5, LAT_ALU);
        set_idle(); s_valid = 1; s_rs1 = 5; s_u1 = 1; cycle();
        set_idle(); wb_both(5); cycle();
        set_idle(); cycle();

        // rd=7 lat=3 with an rs2 consumer held through writeback
        issue(7, LAT_MUL);
        for (int i = 0; i < 5; i++) begin
            set_idle(); s_valid = 1; s_rs2 = 7; s_u2 = 1; cycle();
        end
        set_idle(); s_valid = 1; s_rs2 = 7; s_u2 = 1; wb_both(7); cycle();
        set_idle(); s_valid = 1; s_rs2 = 7; s_u2 = 1; cycle();

        // WAW on rd=9 plus an x0-only instruction
        issue(9, LAT_LOAD);
        for (int i = 0; i < 2; i++) begin
            set_idle(); s_valid = 1; s_rd = 9; s_wr = 1; cycle();
        end
        set_idle(); s_valid = 1; s_rd = 9; s_wr = 1; wb_both(9); cycle();
        set_idle(); s_valid = 1; s_rs1 = 0; s_u1 = 1; s_rd = 0; s_wr = 1; cycle();
        set_idle(); wb_both(9); cycle();

        // three in flight, then flush with a concurrent issue to rd=8
        issue(3, 3); issue(4, 3); issue(6, 3);
        issue(8, 0); s_flush = 1;
        @(negedge clk);
        expq.delete(expq.size() - 1);
        expq.delete(expq.size() - 1);
        do_reset();
        issue(3, 3); issue(4, 3); issue(6, 3);
        set_idle(); s_valid = 1; s_rd = 8; s_wr = 1; s_flush = 1; cycle();
        set_idle(); s_valid = 1; s_rs1 = 8; s_u1 = 1; cycle();
        set_idle(); cycle();

        // stray writeback sets the sticky error; async reset mid-countdown clears everything
        set_idle(); wb_both(12); cycle();
        set_idle(); cycle(); cycle();
        issue(7, 3);
        set_idle(); cycle();
        #3;
        rst = 1'b1;
        #1;
        check("async_busy_cnt", 0, int'(bus0.busy_cnt), 0);
        check("async_stall_cnt", 0, int'(bus0.stall_cnt), 0);
        check("async_wb_err", 0, int'(bus0.wb_err), 0);
        check("async_ready", 0, int'(bus0.issue_ready), 1);
        check("async_wb_err", 1, int'(bus1.wb_err), 0);
        check("async_busy_cnt", 1, int'(bus1.busy_cnt), 0);
        @(negedge clk);
        model_clear();
        rst = 1'b0;

        // randomized traffic; writebacks mostly target registers whose result is ready
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            s_valid = ($urandom_range(0, 9) < 7) ? 1 : 0;
            s_rs1 = $urandom_range(0, 7);
            s_rs2 = $urandom_range(0, 7);
            s_u1  = $urandom_range(0, 1);
            s_u2  = $urandom_range(0, 1);
            s_rd  = $urandom_range(0, 7);
            s_wr  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            s_lat = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 3);
            s_flush = ($urandom_range(0, 29) == 0) ? 1 : 0;
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 199) == 0) begin
                    s_wbv[m] = 1;
                    s_wbr[m] = $urandom_range(0, 15);
                end else if ($urandom_range(0, 9) < 4) begin
                    start = $urandom_range(1, 7);
                    for (int k = 0; k < 7; k++) begin
                        pick = 1 + ((start - 1 + k) % 7);
                        if (s_wbv[m] == 0 && mbusy[m][pick] != 0 && mcnt[m][pick] == 0) begin
                            s_wbv[m] = 1;
                            s_wbr[m] = pick;
                        end
                    end
                end
            end
            cycle();
        end

        set_idle();
        cycle();
        @(negedge clk);
        #4;
        check("queue_drained", 0, expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
